// File: rtl/eth0_cfg_pkg.sv
// eth0_cfg_pkg: register map, CTRL bit positions, FSM states and written-mask type
package eth0_cfg_pkg;
   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_MAC_LO = 8'h04;
   localparam logic [7:0] ADDR_MAC_HI = 8'h08;
   localparam logic [7:0] ADDR_IP     = 8'h0C;
   localparam logic [7:0] ADDR_PORT   = 8'h10;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_SRST = 1;
   localparam int MASK_MAC_LO = 0;
   localparam int MASK_MAC_HI = 1;
   localparam int MASK_IP     = 2;
   localparam int MASK_PORT   = 3;
   typedef logic [3:0] wr_mask_t;
   localparam wr_mask_t MASK_ALL = 4'b1111;
   typedef enum logic {IDLE, COMMIT} cfg_state_t;
endpackage

// File: rtl/eth0_cfg_regfile.sv
// eth0_cfg_regfile: eth0 config write responder; each accepted write is held in a
// shadow stage for COMMIT_CYCLES cycles before it reaches the active registers.
module eth0_cfg_regfile
   import eth0_cfg_pkg::*;
#(
   parameter int          COMMIT_CYCLES = 4,
   parameter logic [15:0] DEF_UDP_PORT  = 16'd5000
) (
   input  logic        clk_hifreq,
   input  logic        rst_n,
   input  logic [7:0]  reg_addr,
   input  logic [31:0] data_in,
   input  logic        wren,
   output logic        busy,
   output logic [47:0] mac_addr,
   output logic [31:0] ip_addr,
   output logic [15:0] udp_port,
   output logic        core_enable,
   output logic        cfg_valid,
   output logic        addr_err,
   output logic        drop_err
);
   cfg_state_t  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic [31:0] mac_lo_q, mac_lo_d;
   logic [15:0] mac_hi_q, mac_hi_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] port_q, port_d;
   logic        en_q, en_d;
   wr_mask_t    mask_q, mask_d;
   logic        valid_q, valid_d;
   logic        aerr_q, aerr_d;
   logic        derr_q, derr_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      busy_d   = busy_q;
      mac_lo_d = mac_lo_q;
      mac_hi_d = mac_hi_q;
      ip_d     = ip_q;
      port_d   = port_q;
      en_d     = en_q;
      mask_d   = mask_q;
      aerr_d   = aerr_q;
      derr_d   = derr_q;
      if (state_q == IDLE) begin
         if (wren) begin
            addr_d  = reg_addr;
            data_d  = data_in;
            cnt_d   = 4'(COMMIT_CYCLES - 1);
            busy_d  = 1'b1;
            state_d = COMMIT;
         end
      end else begin
         if (wren) derr_d = 1'b1;
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd0) begin
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            state_d = IDLE;
            case (addr_q)
               ADDR_CTRL: begin
                  // soft reset wins over enable and also clears the sticky errors
                  if (data_q[CTRL_SRST]) begin
                     mac_lo_d = '0;
                     mac_hi_d = '0;
                     ip_d     = '0;
                     port_d   = DEF_UDP_PORT;
                     en_d     = 1'b0;
                     mask_d   = '0;
                     aerr_d   = 1'b0;
                     derr_d   = 1'b0;
                  end else en_d = data_q[CTRL_EN];
               end
               ADDR_MAC_LO: begin
                  mac_lo_d = data_q;
                  mask_d[MASK_MAC_LO] = 1'b1;
               end
               ADDR_MAC_HI: begin
                  mac_hi_d = data_q[15:0];
                  mask_d[MASK_MAC_HI] = 1'b1;
               end
               ADDR_IP: begin
                  ip_d = data_q;
                  mask_d[MASK_IP] = 1'b1;
               end
               ADDR_PORT: begin
                  port_d = data_q[15:0];
                  mask_d[MASK_PORT] = 1'b1;
               end
               default: aerr_d = 1'b1;
            endcase
         end
      end
      valid_d = (mask_d == MASK_ALL) && en_d;
   end

   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         mac_lo_q <= '0;
         mac_hi_q <= '0;
         ip_q     <= '0;
         port_q   <= DEF_UDP_PORT;
         en_q     <= 1'b0;
         mask_q   <= '0;
         valid_q  <= 1'b0;
         aerr_q   <= 1'b0;
         derr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         mac_lo_q <= mac_lo_d;
         mac_hi_q <= mac_hi_d;
         ip_q     <= ip_d;
         port_q   <= port_d;
         en_q     <= en_d;
         mask_q   <= mask_d;
         valid_q  <= valid_d;
         aerr_q   <= aerr_d;
         derr_q   <= derr_d;
      end
   end

   assign busy        = busy_q;
   assign mac_addr    = {mac_hi_q, mac_lo_q};
   assign ip_addr     = ip_q;
   assign udp_port    = port_q;
   assign core_enable = en_q;
   assign cfg_valid   = valid_q;
   assign addr_err    = aerr_q;
   assign drop_err    = derr_q;
endmodule

// File: tb/tb_eth0_cfg_regfile.sv
// tb_eth0_cfg_regfile: directed bench; a reference model pushes the expected post-commit
// state into a scoreboard queue that is popped when busy falls.
module tb_eth0_cfg_regfile;
   localparam int          CC   = 4;
   localparam logic [15:0] DEFP = 16'd5000;

   logic        clk_hifreq = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [31:0] data_in = '0;
   logic        wren = 1'b0;
   logic        busy, core_enable, cfg_valid, addr_err, drop_err;
   logic [47:0] mac_addr;
   logic [31:0] ip_addr;
   logic [15:0] udp_port;

   eth0_cfg_regfile #(.COMMIT_CYCLES(CC), .DEF_UDP_PORT(DEFP)) dut (
      .clk_hifreq(clk_hifreq), .rst_n(rst_n), .reg_addr(reg_addr), .data_in(data_in),
      .wren(wren), .busy(busy), .mac_addr(mac_addr), .ip_addr(ip_addr),
      .udp_port(udp_port), .core_enable(core_enable), .cfg_valid(cfg_valid),
      .addr_err(addr_err), .drop_err(drop_err)
   );

   always #5 clk_hifreq = ~clk_hifreq;

   typedef struct {
      logic [47:0] mac;
      logic [31:0] ip;
      logic [15:0] port;
      logic        en, valid, aerr, derr;
   } exp_t;

   exp_t        sb[$];
   logic [47:0] m_mac;
   logic [31:0] m_ip;
   logic [15:0] m_port;
   logic        m_en, m_aerr, m_derr;
   logic [3:0]  m_mask;
   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mac = '0; m_ip = '0; m_port = DEFP; m_en = 0; m_mask = '0; m_aerr = 0; m_derr = 0;
   endtask

   task automatic model_apply(input logic [7:0] a, input logic [31:0] d);
      case (a)
         8'h00: if (d[1]) model_reset(); else m_en = d[0];
         8'h04: begin m_mac[31:0] = d; m_mask[0] = 1; end
         8'h08: begin m_mac[47:32] = d[15:0]; m_mask[1] = 1; end
         8'h0C: begin m_ip = d; m_mask[2] = 1; end
         8'h10: begin m_port = d[15:0]; m_mask[3] = 1; end
         default: m_aerr = 1;
      endcase
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.mac = m_mac; e.ip = m_ip; e.port = m_port; e.en = m_en;
      e.valid = (m_mask == 4'hF) && m_en; e.aerr = m_aerr; e.derr = m_derr;
      return e;
   endfunction

   task automatic check_state(input string tag, input exp_t e);
      chk({tag, ".mac"},   64'(mac_addr),    64'(e.mac));
      chk({tag, ".ip"},    64'(ip_addr),     64'(e.ip));
      chk({tag, ".port"},  64'(udp_port),    64'(e.port));
      chk({tag, ".en"},    64'(core_enable), 64'(e.en));
      chk({tag, ".valid"}, 64'(cfg_valid),   64'(e.valid));
      chk({tag, ".aerr"},  64'(addr_err),    64'(e.aerr));
      chk({tag, ".derr"},  64'(drop_err),    64'(e.derr));
   endtask

   // intr_at>0 drives a second wren on that busy cycle, which must be dropped
   task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                           input int intr_at = 0, input logic [7:0] a2 = '0,
                           input logic [31:0] d2 = '0);
      int n = 0;
      exp_t e;
      reg_addr = a; data_in = d; wren = 1;
      if (intr_at > 0) m_derr = 1;
      model_apply(a, d);
      sb.push_back(snap());
      @(posedge clk_hifreq); #1;
      wren = 0;
      while (busy && n < 64) begin
         n++;
         if (n == intr_at) begin reg_addr = a2; data_in = d2; wren = 1; end
         @(posedge clk_hifreq); #1;
         wren = 0;
      end
      chk({tag, ".busy_len"}, 64'(n), 64'(CC));
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 64'(0), 64'(1));
      else begin
         e = sb.pop_front();
         check_state(tag, e);
      end
   endtask

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk_hifreq);
      #1 rst_n = 1;
      @(posedge clk_hifreq); #1;
      model_reset();
      chk("reset.busy", 64'(busy), 64'(0));
      check_state("reset", snap());

      do_write("ip", 8'h0C, 32'hC0A8_0001);
      do_write("mac_lo", 8'h04, 32'h3344_5566);
      do_write("mac_hi", 8'h08, 32'hFFFF_1122);
      do_write("port", 8'h10, 32'h0000_1388);
      chk("pre_ctrl.valid", 64'(cfg_valid), 64'(0));
      do_write("ctrl_en", 8'h00, 32'h0000_0001);
      chk("full.mac", 64'(mac_addr), 64'h1122_3344_5566);

      do_write("drop", 8'h04, 32'hAABB_CCDD, 2, 8'h04, 32'h0BAD_0BAD);
      do_write("bad_addr", 8'h14, 32'h1234_5678);
      do_write("unaligned", 8'h05, 32'h0000_0000);
      do_write("srst", 8'h00, 32'h0000_0003);
      chk("srst.mac", 64'(mac_addr), 64'(0));

      do_write("mac_lo2", 8'h04, 32'h1111_1111);
      reg_addr = 8'h04; data_in = 32'hDEAD_BEEF; wren = 1;
      @(posedge clk_hifreq); #1;
      wren = 0;
      @(posedge clk_hifreq); #1;
      chk("arst.pre_busy", 64'(busy), 64'(1));
      rst_n = 0;
      #1;
      model_reset();
      sb.delete();
      chk("arst.busy", 64'(busy), 64'(0));
      check_state("arst", snap());
      @(posedge clk_hifreq); #1;
      rst_n = 1;
      repeat (CC + 2) @(posedge clk_hifreq);
      #1;
      chk("arst_rel.busy", 64'(busy), 64'(0));
      check_state("arst_rel", snap());

      do_write("post_ip", 8'h0C, 32'h0A00_0002);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/eth0_cfg_regfile.md
Name: eth0_cfg_regfile

Overview:
- Responder end of the eth0 configuration write interface. The initiator drives reg_addr/data_out/wren and holds off while busy is high.
- Accepts one 32-bit register write at a time and holds it in a shadow stage for a fixed commit latency, so core-side settings never change mid-cycle.
- Updates the active configuration registers that feed the Ethernet/UDP datapath.
- Flags unmapped addresses and writes dropped during busy, and reports when the core is fully configured.

Parameters:
- COMMIT_CYCLES, 4, cycles busy stays high per accepted write; legal range 1..15.
- DEF_UDP_PORT, 16'd5000, reset value of udp_port.

Ports:
- clk_hifreq  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- reg_addr  in  8  register byte address, sampled with wren.
- data_in  in  32  write data, sampled with wren.
- wren  in  1  write request; single-cycle or held.
- busy  out  1  high while a write is committing; the initiator must not assert wren.
- mac_addr  out  48  active MAC, {MAC_HI[15:0], MAC_LO}.
- ip_addr  out  32  active IPv4 address.
- udp_port  out  16  active UDP port.
- core_enable  out  1  CTRL[0].
- cfg_valid  out  1  high when MAC_LO, MAC_HI, IP and PORT have each been written since reset or soft reset, AND core_enable=1.
- addr_err  out  1  sticky; an unmapped address was accepted.
- drop_err  out  1  sticky; wren was seen while busy.

Behaviour:
- Reset (rst_n=0, async):
  - busy=0, mac_addr=0, ip_addr=0, udp_port=DEF_UDP_PORT.
  - core_enable=0, cfg_valid=0, addr_err=0, drop_err=0.
  - Written-mask=0, state=IDLE.
- Register map, word aligned:
  - 0x00 CTRL: [0] enable; [1] soft_reset, self-clearing, never stored.
  - 0x04 MAC_LO [31:0].
  - 0x08 MAC_HI [15:0]; upper bits ignored.
  - 0x0C IP [31:0].
  - 0x10 PORT [15:0]; upper bits ignored.
- FSM states IDLE, COMMIT:
  - IDLE: on wren=1 at edge T, latch reg_addr/data_in into the shadow stage, load counter=COMMIT_CYCLES-1, go to COMMIT. busy is registered and is 1 from T+1.
  - COMMIT: counter decrements each cycle. On the cycle the counter is 0:
    - write shadow data to the active register;
    - set the corresponding written-mask bit;
    - return to IDLE.
  - busy=1 for exactly COMMIT_CYCLES cycles (T+1..T+COMMIT_CYCLES). The output reflects the new value at T+COMMIT_CYCLES+1, and busy=0 in that same cycle.
- Back-to-back: wren is sampled in the first IDLE cycle after busy falls. A held wren therefore produces repeated writes of the current address/data.
- wren while in COMMIT: write discarded, drop_err<=1. Shadow data is unchanged.
- Unmapped or unaligned address: transaction still takes the full COMMIT_CYCLES of busy. No register changes, addr_err<=1.
- Soft reset (CTRL with data[1]=1) at commit:
  - all active registers and the written-mask return to reset values; udp_port=DEF_UDP_PORT;
  - data[0] is ignored;
  - addr_err/drop_err are cleared.
- cfg_valid is registered and is (mask==4'b1111) && core_enable. It updates in the same cycle as the committed register.
- rst_n asserted mid-COMMIT: the pending write is lost, and all outputs immediately take reset values.

Decomposition:
- Package eth0_cfg_pkg holds:
  - address localparams ADDR_CTRL, ADDR_MAC_LO, ADDR_MAC_HI, ADDR_IP, ADDR_PORT;
  - CTRL bit indices;
  - cfg_state_t enum {IDLE, COMMIT};
  - the typedef for the 4-bit written-mask.
- No sub-module required. The commit counter and register decode are both inline.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release → busy=0, udp_port=5000, mac_addr=0, cfg_valid=0, errors=0.
- Single write latency: wren 1 cycle with addr 0x0C, data 0xC0A8_0001, COMMIT_CYCLES=4 → busy high exactly 4 cycles, ip_addr=0xC0A80001 the cycle busy falls, no errors.
- Full config: write MAC_LO=0x3344_5566, MAC_HI=0xFFFF_1122, IP, PORT=0x1388, CTRL=0x1 → mac_addr=48'h1122_3344_5566 and cfg_valid=1 after the CTRL commit, not before.
- Protocol violation: wren to 0x04 on the 2nd busy cycle of a write → drop_err=1, mac_addr keeps the first write's value, busy length unchanged.
- Bad address plus soft reset: write 0x14 → addr_err=1 after 4 busy cycles, no outputs change. Then CTRL=0x2 → all registers back to reset values, cfg_valid=0, addr_err=0.
- Async reset mid-commit: rst_n low on the 2nd busy cycle of a MAC_LO write → busy=0 and mac_addr=0 immediately; MAC_LO is not updated after release.
